reg_file_sb: RTL and testbench

- Parametrised successor to the core's 32x32 register file.
- Two combinational read ports and one write port with the existing write-select modes: write to read address A, write to read address B, or write to the link register.
- Adds an optional hardwired zero register, write-to-read bypass, and a per-register pending scoreboard so the issue stage can detect RAW hazards on in-flight writebacks.
- Sits between decode/issue (reads, reservations) and writeback (writes, releases).

---
 rtl/reg_file_sb.sv | 109 ++++++++++
 tb/tb_reg_file_sb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file: two combinational read ports, one write port with
// address-select modes, optional hardwired zero register, write bypass and pending scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [1:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0] waddr;
  logic              wr_req;
  logic              wr_en;
  logic              rsv_ok;
  logic              cnt_inc;
  logic              cnt_dec;

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rbusy [2];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Write address decode; wr_sel 10/11 reuse the read addresses of the same cycle.
  always_comb begin
    waddr  = '0;
    wr_req = 1'b0;
    unique case (wr_sel)
      2'b10: begin waddr = rd_addr_a; wr_req = 1'b1; end
      2'b11: begin waddr = rd_addr_b; wr_req = 1'b1; end
      2'b01: begin waddr = '1;        wr_req = 1'b1; end
      default: begin waddr = '0;      wr_req = 1'b0; end
    endcase
    wr_en  = wr_req && !rst && !is_zero(waddr);
    rsv_ok = rsv_en && !rst && !is_zero(rsv_addr);
  end

  // Reservation is applied after the write clear so a same-address reserve wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)  pend_d[waddr]    = 1'b0;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    cnt_inc = rsv_ok && !pend_q[rsv_addr];
    cnt_dec = wr_en && pend_q[waddr] && !(rsv_ok && (rsv_addr == waddr));
    cnt_d   = cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    raddr[0] = rd_addr_a;
    raddr[1] = rd_addr_b;
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem_q[raddr[p]];
      rbusy[p] = pend_q[raddr[p]];
      if (is_zero(raddr[p])) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end else if (BYPASS && wr_en && (waddr == raddr[p])) begin
        rdata[p] = wr_data;
        rbusy[p] = rsv_ok && (rsv_addr == raddr[p]);
      end
    end
  end

  assign rd_data_a = rdata[0];
  assign rd_data_b = rdata[1];
  assign busy_a    = rbusy[0];
  assign busy_b    = rbusy[1];
  assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default instance (zero reg + bypass) and a plain instance
// (neither), checked against a behavioural model plus a hand-derived vector table.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] rd_addr_a, rd_addr_b, rsv_addr;
  logic [1:0]    wr_sel;
  logic [DW-1:0] wr_data;
  logic          rsv_en;

  logic [DW-1:0] da0, db0, da1, db1;
  logic          ba0, bb0, ba1, bb1;
  logic [AW:0]   pc0, pc1;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da0), .rd_data_b(db0), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(ba0), .busy_b(bb0), .pend_cnt(pc0));

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_plain (
    .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da1), .rd_data_b(db1), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(ba1), .busy_b(bb1), .pend_cnt(pc1));

  typedef struct {
    logic          r;
    logic [1:0]    ws;
    logic [AW-1:0] a, b;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    bit            ck;
    logic [DW-1:0] ea, eb;
    logic          eba, ebb;
    int            ec;
  } vec_t;

  typedef struct {
    logic [DW-1:0] a [2];
    logic [DW-1:0] b [2];
    logic          ba [2];
    logic          bb [2];
    int            c [2];
  } exp_t;

  exp_t sb_q[$];

  logic [DW-1:0] m_mem [2][DEPTH];
  bit            m_pend [2][DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] ws, input logic [AW-1:0] a,
                              input logic [AW-1:0] b, input logic [DW-1:0] wd, input logic re,
                              input logic [AW-1:0] ra, input bit ck, input logic [DW-1:0] ea,
                              input logic [DW-1:0] eb, input logic eba, input logic ebb,
                              input int ec);
    vec_t v;
    v.r = r; v.ws = ws; v.a = a; v.b = b; v.wd = wd; v.re = re; v.ra = ra;
    v.ck = ck; v.ea = ea; v.eb = eb; v.eba = eba; v.ebb = ebb; v.ec = ec;
    return v;
  endfunction

  // Model configuration c: 0 = zero register + bypass, 1 = neither.
  function automatic logic [AW-1:0] m_waddr();
    case (wr_sel)
      2'b10:   return rd_addr_a;
      2'b11:   return rd_addr_b;
      2'b01:   return AW'(DEPTH - 1);
      default: return '0;
    endcase
  endfunction

  function automatic bit m_we(input int c);
    return !rst && (wr_sel != 2'b00) && !((c == 0) && (m_waddr() == 0));
  endfunction

  function automatic bit m_rv(input int c);
    return !rst && rsv_en && !((c == 0) && (rsv_addr == 0));
  endfunction

  task automatic m_read(input int c, input logic [AW-1:0] ad, output logic [DW-1:0] d,
                        output logic bz);
    if (c == 0 && ad == 0) begin
      d = '0; bz = 1'b0;
    end else if (c == 0 && m_we(c) && m_waddr() == ad) begin
      d = wr_data; bz = m_rv(c) && (rsv_addr == ad);
    end else begin
      d = m_mem[c][ad]; bz = m_pend[c][ad];
    end
  endtask

  function automatic int m_cnt(input int c);
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[c][i]);
    return n;
  endfunction

  task automatic m_step();
    logic [AW-1:0] wa;
    wa = m_waddr();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[c][i] = '0; m_pend[c][i] = 1'b0; end
      end else begin
        if (m_we(c)) begin m_mem[c][wa] = wr_data; m_pend[c][wa] = 1'b0; end
        if (m_rv(c)) m_pend[c][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic cycle(input vec_t v, input bit tbl);
    exp_t e;
    rst = v.r; wr_sel = v.ws; rd_addr_a = v.a; rd_addr_b = v.b;
    wr_data = v.wd; rsv_en = v.re; rsv_addr = v.ra;
    #1;
    for (int c = 0; c < 2; c++) begin
      m_read(c, v.a, e.a[c], e.ba[c]);
      m_read(c, v.b, e.b[c], e.bb[c]);
      e.c[c] = m_cnt(c);
    end
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      if (v.ck) begin
        check("m0_rd_a", 64'(da0), 64'(e.a[0]));  check("m0_rd_b", 64'(db0), 64'(e.b[0]));
        check("m0_busy_a", 64'(ba0), 64'(e.ba[0])); check("m0_busy_b", 64'(bb0), 64'(e.bb[0]));
        check("m0_cnt", 64'(pc0), 64'(e.c[0]));
        check("m1_rd_a", 64'(da1), 64'(e.a[1]));  check("m1_rd_b", 64'(db1), 64'(e.b[1]));
        check("m1_busy_a", 64'(ba1), 64'(e.ba[1])); check("m1_busy_b", 64'(bb1), 64'(e.bb[1]));
        check("m1_cnt", 64'(pc1), 64'(e.c[1]));
        if (tbl) begin
          check("t_rd_a", 64'(da0), 64'(v.ea));   check("t_rd_b", 64'(db0), 64'(v.eb));
          check("t_busy_a", 64'(ba0), 64'(v.eba)); check("t_busy_b", 64'(bb0), 64'(v.ebb));
          check("t_cnt", 64'(pc0), 64'(v.ec));
        end
      end
    end
    m_step();
    @(posedge clk);
    #1;
  endtask

  vec_t tv [20];
  vec_t v;

  initial begin
    tv[0]  = mk(0, 2'b00, 0, 31, 32'h0,        0, 0, 1, 32'h0,        32'h0,        0, 0, 0);
    tv[1]  = mk(0, 2'b10, 5, 5,  32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tv[2]  = mk(0, 2'b00, 0, 5,  32'h0,        0, 0, 1, 32'h0,        32'hDEADBEEF, 0, 0, 0);
    tv[3]  = mk(0, 2'b01, 31, 5, 32'h00400020, 0, 0, 1, 32'h00400020, 32'hDEADBEEF, 0, 0, 0);
    tv[4]  = mk(0, 2'b11, 31, 0, 32'h1234,     0, 0, 1, 32'h00400020, 32'h0,        0, 0, 0);
    tv[5]  = mk(0, 2'b00, 3, 0,  32'h0,        1, 3, 1, 32'h0,        32'h0,        0, 0, 0);
    tv[6]  = mk(0, 2'b00, 3, 7,  32'h0,        1, 7, 1, 32'h0,        32'h0,        1, 0, 1);
    tv[7]  = mk(0, 2'b00, 7, 3,  32'h0,        1, 3, 1, 32'h0,        32'h0,        1, 1, 2);
    tv[8]  = mk(0, 2'b10, 7, 3,  32'h77,       0, 0, 1, 32'h77,       32'h0,        0, 1, 2);
    tv[9]  = mk(0, 2'b00, 7, 3,  32'h0,        0, 0, 1, 32'h77,       32'h0,        0, 1, 1);
    tv[10] = mk(0, 2'b10, 9, 7,  32'h55,       1, 9, 1, 32'h55,       32'h77,       1, 0, 1);
    tv[11] = mk(0, 2'b00, 9, 0,  32'h0,        1, 0, 1, 32'h55,       32'h0,        1, 0, 2);
    tv[12] = mk(0, 2'b00, 9, 3,  32'h0,        0, 0, 1, 32'h55,       32'h0,        1, 1, 2);
    tv[13] = mk(0, 2'b00, 1, 2,  32'h0,        1, 1, 1, 32'h0,        32'h0,        0, 0, 2);
    tv[14] = mk(0, 2'b00, 1, 2,  32'h0,        1, 2, 1, 32'h0,        32'h0,        1, 0, 3);
    tv[15] = mk(0, 2'b10, 4, 1,  32'hAAAA,     1, 4, 1, 32'hAAAA,     32'h0,        1, 1, 4);
    tv[16] = mk(1, 2'b10, 6, 4,  32'hFFFF,     1, 8, 0, 32'h0,        32'h0,        0, 0, 0);
    tv[17] = mk(0, 2'b00, 6, 4,  32'h0,        0, 0, 1, 32'h0,        32'h0,        0, 0, 0);
    tv[18] = mk(0, 2'b00, 9, 31, 32'h0,        0, 0, 1, 32'h0,        32'h0,        0, 0, 0);
    tv[19] = mk(0, 2'b00, 5, 7,  32'h0,        0, 0, 1, 32'h0,        32'h0,        0, 0, 0);

    rst = 1'b1; wr_sel = 2'b00; rd_addr_a = '0; rd_addr_b = '0;
    wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
    @(posedge clk);
    #1;
    cycle(mk(1, 2'b00, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0), 1'b0);

    for (int i = 0; i < DEPTH; i++)
      cycle(mk(0, 2'b00, AW'(i), AW'(DEPTH - 1 - i), 32'h0, 0, 0, 1, 32'h0, 32'h0, 0, 0, 0), 1'b1);

    for (int i = 0; i < 20; i++) cycle(tv[i], 1'b1);

    // Fill the scoreboard completely, then drain it with writes.
    for (int i = 0; i < DEPTH; i++)
      cycle(mk(0, 2'b00, AW'(i), AW'(i + 1), 32'h0, 1, AW'(i), 1, 0, 0, 0, 0, 0), 1'b0);
    cycle(mk(0, 2'b00, 0, 31, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
    check("full_cnt_zero_reg", 64'(pc0), 64'd31);
    check("full_cnt_plain", 64'(pc1), 64'd32);
    for (int i = 0; i < DEPTH; i++)
      cycle(mk(0, 2'b10, AW'(i), 0, DW'(i * 3 + 1), 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
    cycle(mk(0, 2'b00, 1, 2, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
    check("drain_cnt_zero_reg", 64'(pc0), 64'd0);
    check("drain_cnt_plain", 64'(pc1), 64'd0);
    check("drain_rd_a", 64'(da0), 64'd4);

    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(0, 79) == 0), 2'($urandom_range(0, 3)),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), 1, 0, 0, 0, 0, 0);
      if (i % 5 == 0) v.a = AW'(31);
      v.ck = !v.r;
      cycle(v, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
